// File: rtl/seven_seg_scan.sv
// seven_seg_scan: time-multiplexed common-anode seven-segment driver with load handshake
module seven_seg_scan #(
    parameter int N_DIGITS     = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_load,
    input  logic [4*N_DIGITS-1:0] i_value,
    input  logic                  i_hex_mode,
    input  logic                  i_blank_lz,
    input  logic                  i_blink_en,
    output logic [6:0]            o_seg,
    output logic [N_DIGITS-1:0]   o_an,
    output logic                  o_ack
);
    localparam int W  = 4 * N_DIGITS;
    localparam int IW = $clog2(N_DIGITS);
    localparam int CW = $clog2(SCAN_DIV);
    localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [111:0] GLYPHS = {
        7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
        7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
        7'b1011000, 7'b0000010, 7'b0010010, 7'b0011001,
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };
    logic [CW-1:0]       cnt;
    logic [IW-1:0]       idx, nidx;
    logic [FW-1:0]       fc;
    logic [W-1:0]        pend, disp, src;
    logic                pflag, phase, nphase;
    logic                tick, boundary, apply, run;
    logic [3:0]          nib;
    logic [N_DIGITS-1:0] lz, an_n;
    logic [6:0]          seg_n;
    assign tick     = cnt == CW'(SCAN_DIV - 1);
    assign nidx     = idx == IW'(N_DIGITS - 1) ? '0 : idx + 1'b1;
    assign boundary = tick && nidx == '0;
    assign apply    = boundary && pflag;
    assign src      = apply ? pend : disp;
    assign nib      = src[{nidx, 2'b00} +: 4];
    assign nphase   = boundary && fc == FW'(BLINK_FRAMES - 1) ? ~phase : phase;
    // lz[k] is set when nibbles k..top of the value being shown are all zero
    always_comb begin
        lz  = '0;
        run = 1'b1;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            run   = run && src[4*k +: 4] == 4'd0;
            lz[k] = run;
        end
    end
    // next pin values for the digit selected by the upcoming tick
    always_comb begin
        an_n  = i_blink_en && nphase ? '1 : ~(N_DIGITS'(1) << nidx);
        seg_n = (i_blink_en && nphase) || (i_blank_lz && nidx != '0 && lz[nidx]) ||
                (nib > 4'd9 && !i_hex_mode) ? 7'h7F : GLYPHS[7*nib +: 7];
    end
    // prescaler and digit scan index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= IW'(N_DIGITS - 1);
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick) idx <= nidx;
        end
    end
    // free-running frame counter and blink phase (1 = hidden)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fc    <= '0;
            phase <= 1'b0;
        end else if (boundary) begin
            fc    <= fc == FW'(BLINK_FRAMES - 1) ? '0 : fc + 1'b1;
            phase <= nphase;
        end
    end
    // load capture and frame-aligned apply; a load on a boundary waits a frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend  <= '0;
            disp  <= '0;
            pflag <= 1'b0;
        end else begin
            if (apply) disp <= pend;
            if (i_load) pend <= i_value;
            pflag <= i_load || (pflag && !apply);
        end
    end
    // registered pin drive, updated only on scan ticks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_seg <= 7'h7F;
            o_an  <= '1;
            o_ack <= 1'b0;
        end else begin
            o_ack <= apply;
            if (tick) begin
                o_seg <= seg_n;
                o_an  <= an_n;
            end
        end
    end
endmodule

// File: tb/tb_seven_seg_scan.sv
// tb_seven_seg_scan: table-driven and randomized checks against a cycle-count reference model
module tb_seven_seg_scan;
    localparam int N = 4, SD = 4, BF = 2;
    typedef struct packed {
        logic [15:0] val;
        logic        hex;
        logic        blz;
        logic [27:0] segs;
    } vec_t;
    logic clk = 0, rst_n = 0, i_load = 0, i_hex_mode = 0, i_blank_lz = 0, i_blink_en = 0;
    logic [15:0] i_value = 0;
    logic [6:0]  o_seg;
    logic [3:0]  o_an;
    logic        o_ack;
    int total = 0, bad = 0;
    int cyc, ticks, bcount;
    logic [15:0] m_disp, m_pend;
    bit m_pflag, m_ack;
    logic [6:0] m_seg;
    logic [3:0] m_an;
    logic [6:0] gl [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                            7'b0011001, 7'b0010010, 7'b0000010, 7'b1011000,
                            7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                            7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    vec_t tbl [9];

    seven_seg_scan #(.N_DIGITS(N), .SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .rst_n(rst_n), .i_load(i_load), .i_value(i_value),
        .i_hex_mode(i_hex_mode), .i_blank_lz(i_blank_lz), .i_blink_en(i_blink_en),
        .o_seg(o_seg), .o_an(o_an), .o_ack(o_ack)
    );

    always #5 clk = ~clk;

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at cyc=%0d got=%0h want=%0h", name, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        cyc = 0; ticks = 0; bcount = 0;
        m_disp = 0; m_pend = 0; m_pflag = 0; m_ack = 0;
        m_seg = 7'h7F; m_an = 4'hF;
    endtask

    // one clock edge of the display as described: ticks every SD cycles, digits in rotation
    task automatic model_edge();
        cyc++;
        m_ack = 0;
        if (cyc % SD == 0) begin
            int d;
            logic [15:0] rest;
            ticks++;
            d = (ticks - 1) % N;
            if (d == 0) begin
                bcount++;
                if (m_pflag) begin
                    m_disp = m_pend; m_pflag = 0; m_ack = 1;
                end
            end
            rest = m_disp >> (4 * d);
            if (i_blink_en && (bcount / BF) % 2 == 1) begin
                m_seg = 7'h7F; m_an = 4'hF;
            end else begin
                m_an = ~(4'b1 << d);
                if (d > 0 && i_blank_lz && rest == 0) m_seg = 7'h7F;
                else if (rest[3:0] > 9 && !i_hex_mode) m_seg = 7'h7F;
                else m_seg = gl[rest[3:0]];
            end
        end
        if (i_load) begin
            m_pend = i_value; m_pflag = 1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("cycle {ack,an,seg}", {o_ack, o_an, o_seg}, {m_ack, m_an, m_seg});
    endtask

    task automatic steps(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic load(logic [15:0] v);
        i_value = v; i_load = 1;
        step();
        i_load = 0;
    endtask

    task automatic wait_ack();
        for (int k = 0; k < 64 && !m_ack; k++) step();
        check("ack", o_ack, 1);
    endtask

    task automatic to_boundary();
        for (int k = 0; k < 64 && !(((cyc + 1) % SD == 0) && (ticks % N == 0)); k++) step();
    endtask

    initial begin
        int acks;
        tbl[0] = '{16'h1234, 1'b0, 1'b0, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}};
        tbl[1] = '{16'hABCD, 1'b1, 1'b0, {7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001}};
        tbl[2] = '{16'hABCD, 1'b0, 1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h7F}};
        tbl[3] = '{16'h0050, 1'b0, 1'b1, {7'h7F, 7'h7F, 7'b0010010, 7'b1000000}};
        tbl[4] = '{16'h0000, 1'b0, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'b1000000}};
        tbl[5] = '{16'h1000, 1'b0, 1'b1, {7'b1111001, 7'b1000000, 7'b1000000, 7'b1000000}};
        tbl[6] = '{16'h0050, 1'b0, 1'b0, {7'b1000000, 7'b1000000, 7'b0010010, 7'b1000000}};
        tbl[7] = '{16'h9876, 1'b0, 1'b0, {7'b0010000, 7'b0000000, 7'b1011000, 7'b0000010}};
        tbl[8] = '{16'hFE0A, 1'b1, 1'b1, {7'b0001110, 7'b0000110, 7'b1000000, 7'b0001000}};
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset seg", o_seg, 7'h7F);
        check("reset an", o_an, 4'hF);
        check("reset ack", o_ack, 0);
        rst_n = 1;
        model_reset();
        for (int k = 0; k < N; k++) begin
            steps(SD);
            check("scan an", o_an, ~(4'b1 << k) & 4'hF);
            check("scan seg", o_seg, 7'b1000000);
        end
        foreach (tbl[v]) begin
            i_hex_mode = tbl[v].hex;
            i_blank_lz = tbl[v].blz;
            load(tbl[v].val);
            wait_ack();
            for (int d = 0; d < N; d++) begin
                if (d > 0) steps(SD);
                check("vec seg", o_seg, tbl[v].segs[7*d +: 7]);
                check("vec an", o_an, ~(4'b1 << d) & 4'hF);
            end
        end
        i_hex_mode = 0; i_blank_lz = 0;
        to_boundary();
        step();
        load(16'h1111);
        steps(3);
        load(16'h2222);
        acks = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (o_ack) begin
                acks++;
                check("latest wins seg", o_seg, 7'b0100100);
            end
        end
        check("single ack", acks, 1);
        to_boundary();
        i_value = 16'h3333; i_load = 1;
        step();
        i_load = 0;
        check("no ack on boundary load", o_ack, 0);
        steps(SD * N - 1);
        check("ack not early", o_ack, 0);
        step();
        check("boundary load ack", o_ack, 1);
        check("boundary load seg", o_seg, 7'b0110000);
        load(16'h4444);
        to_boundary();
        i_value = 16'h5555; i_load = 1;
        step();
        i_load = 0;
        check("older pending ack", o_ack, 1);
        check("older pending seg", o_seg, 7'b0011001);
        steps(SD * N);
        check("newer pending ack", o_ack, 1);
        check("newer pending seg", o_seg, 7'b0010010);
        i_blink_en = 1;
        steps(SD * N * 2 * BF * 3);
        i_blink_en = 0;
        to_boundary();
        steps(3);
        load(16'h7777);
        steps(2);
        rst_n = 0;
        #1;
        check("async reset seg", o_seg, 7'h7F);
        check("async reset an", o_an, 4'hF);
        check("async reset ack", o_ack, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        model_reset();
        acks = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (o_ack) acks++;
        end
        check("no ack after reset", acks, 0);
        for (int k = 0; k < 600; k++) begin
            i_load = $urandom_range(0, 5) == 0;
            i_value = 16'($urandom_range(0, 65535) >> $urandom_range(0, 16));
            if ($urandom_range(0, 15) == 0) begin
                i_hex_mode = 1'($urandom);
                i_blank_lz = 1'($urandom);
            end
            if ($urandom_range(0, 63) == 0) i_blink_en = 1'($urandom);
            step();
        end
        i_load = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
